// File: rtl/line_pkg.sv
// Shared definitions for the line-register queue writers: coordinate width,
// screen geometry, the queued line record and the pattern writer's enums.
package line_pkg;

   localparam int LINE_W = 13;
   localparam int SCR_W  = 640;
   localparam int SCR_H  = 480;

   typedef struct packed {
      logic [LINE_W-1:0] sx;
      logic [LINE_W-1:0] sy;
      logic [LINE_W-1:0] ex;
      logic [LINE_W-1:0] ey;
      logic [3:0]        intensity;
   } line_t;

   typedef enum logic [1:0] {
      PAT_BORDER = 2'd0,
      PAT_CROSS  = 2'd1,
      PAT_GRID   = 2'd2,
      PAT_NONE   = 2'd3
   } pattern_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } wr_state_e;

endpackage

// File: rtl/line_pattern_rom.sv
// Combinational table of the fixed overlay patterns: for a pattern and line
// index it gives the segment endpoints and flags the pattern's final line.
module line_pattern_rom #(
   parameter int LINE_W = line_pkg::LINE_W
) (
   input  logic [1:0]        pattern,
   input  logic [3:0]        idx,
   output logic [LINE_W-1:0] sx,
   output logic [LINE_W-1:0] sy,
   output logic [LINE_W-1:0] ex,
   output logic [LINE_W-1:0] ey,
   output logic              last
);
   import line_pkg::*;

   localparam int X_MAX = SCR_W - 1;
   localparam int Y_MAX = SCR_H - 1;
   localparam int X_MID = SCR_W / 2;
   localparam int Y_MID = SCR_H / 2;
   localparam int ARM   = 16;
   localparam int GRID_DX = SCR_W / 8;
   localparam int GRID_DY = SCR_H / 8;

   function automatic logic [LINE_W-1:0] coord(input int v);
      return LINE_W'(v);
   endfunction

   always_comb begin
      sx   = '0;
      sy   = '0;
      ex   = '0;
      ey   = '0;
      last = 1'b1;
      case (pattern_e'(pattern))
         PAT_BORDER: begin
            last = (idx == 4'd3);
            case (idx[1:0])
               2'd0: begin sx = coord(0);     sy = coord(0);     ex = coord(X_MAX); ey = coord(0);     end
               2'd1: begin sx = coord(X_MAX); sy = coord(0);     ex = coord(X_MAX); ey = coord(Y_MAX); end
               2'd2: begin sx = coord(X_MAX); sy = coord(Y_MAX); ex = coord(0);     ey = coord(Y_MAX); end
               default: begin sx = coord(0);  sy = coord(Y_MAX); ex = coord(0);     ey = coord(0);     end
            endcase
         end
         PAT_CROSS: begin
            last = (idx == 4'd1);
            if (!idx[0]) begin
               sx = coord(X_MID - ARM); sy = coord(Y_MID);
               ex = coord(X_MID + ARM); ey = coord(Y_MID);
            end else begin
               sx = coord(X_MID); sy = coord(Y_MID - ARM);
               ex = coord(X_MID); ey = coord(Y_MID + ARM);
            end
         end
         PAT_GRID: begin
            last = (idx == 4'd15);
            // Indices 0..7 are the verticals, 8..15 the horizontals.
            if (!idx[3]) begin
               sx = coord(GRID_DX * int'(idx[2:0])); sy = coord(0);
               ex = coord(GRID_DX * int'(idx[2:0])); ey = coord(Y_MAX);
            end else begin
               sx = coord(0);     sy = coord(GRID_DY * int'(idx[2:0]));
               ex = coord(X_MAX); ey = coord(GRID_DY * int'(idx[2:0]));
            end
         end
         default: begin
            last = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/line_pattern_writer.sv
// Second writer on the line queue: while AVG is halted it emits a fixed overlay
// pattern, yielding every cycle to AVG writes, which pass through untouched.
module line_pattern_writer #(
   parameter int LINE_W = line_pkg::LINE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        pattern,
   input  logic [3:0]        intensity,
   input  logic              avg_halt,
   input  logic              avg_wr,
   input  logic [LINE_W-1:0] avg_sx,
   input  logic [LINE_W-1:0] avg_sy,
   input  logic [LINE_W-1:0] avg_ex,
   input  logic [LINE_W-1:0] avg_ey,
   input  logic [3:0]        avg_int,
   input  logic              q_full,
   output logic              q_wr,
   output logic [LINE_W-1:0] q_sx,
   output logic [LINE_W-1:0] q_sy,
   output logic [LINE_W-1:0] q_ex,
   output logic [LINE_W-1:0] q_ey,
   output logic [3:0]        q_int,
   output logic              busy,
   output logic              done
);
   import line_pkg::*;

   wr_state_e         state_q;
   pattern_e          pat_q;
   logic [3:0]        int_q;
   logic [3:0]        idx_q;
   logic [LINE_W-1:0] sx_q, sy_q, ex_q, ey_q;
   logic              last_q;

   logic [1:0]        rom_pat;
   logic [3:0]        rom_idx;
   logic [LINE_W-1:0] rom_sx, rom_sy, rom_ex, rom_ey;
   logic              rom_last;
   logic              wr_w;

   // In IDLE the table is addressed with the incoming request so line 0 is
   // registered in time for the first attempt; otherwise it looks one line ahead.
   assign rom_pat = (state_q == ST_IDLE) ? pattern : pat_q;
   assign rom_idx = (state_q == ST_IDLE) ? 4'd0 : idx_q + 4'd1;

   line_pattern_rom #(.LINE_W(LINE_W)) u_rom (
      .pattern (rom_pat),
      .idx     (rom_idx),
      .sx      (rom_sx),
      .sy      (rom_sy),
      .ex      (rom_ex),
      .ey      (rom_ey),
      .last    (rom_last)
   );

   assign wr_w = (state_q == ST_EMIT) & avg_halt & ~q_full & ~avg_wr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pat_q   <= PAT_BORDER;
         int_q   <= '0;
         idx_q   <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         ex_q    <= '0;
         ey_q    <= '0;
         last_q  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  pat_q <= pattern_e'(pattern);
                  int_q <= intensity;
                  idx_q <= '0;
                  busy  <= 1'b1;
                  if (pattern_e'(pattern) == PAT_NONE) begin
                     state_q <= ST_DONE;
                     done    <= 1'b1;
                  end else begin
                     state_q <= ST_EMIT;
                     sx_q    <= rom_sx;
                     sy_q    <= rom_sy;
                     ex_q    <= rom_ex;
                     ey_q    <= rom_ey;
                     last_q  <= rom_last;
                  end
               end
            end
            ST_EMIT: begin
               if (wr_w) state_q <= ST_GAP;
            end
            // One dead cycle lets the registered queue-full flag catch up.
            ST_GAP: begin
               if (last_q) begin
                  state_q <= ST_DONE;
                  done    <= 1'b1;
               end else begin
                  state_q <= ST_EMIT;
                  idx_q   <= idx_q + 4'd1;
                  sx_q    <= rom_sx;
                  sy_q    <= rom_sy;
                  ex_q    <= rom_ex;
                  ey_q    <= rom_ey;
                  last_q  <= rom_last;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   assign q_wr  = avg_wr | wr_w;
   assign q_sx  = avg_wr ? avg_sx  : sx_q;
   assign q_sy  = avg_wr ? avg_sy  : sy_q;
   assign q_ex  = avg_wr ? avg_ex  : ex_q;
   assign q_ey  = avg_wr ? avg_ey  : ey_q;
   assign q_int = avg_wr ? avg_int : int_q;

endmodule

// File: tb/tb_line_pattern_writer.sv
// Scoreboard bench for line_pattern_writer: expected queue writes and done
// pulses are queued with their cycle numbers and matched as the DUT emits them.
module tb_line_pattern_writer;
   localparam int W = 13;

   logic         clk = 1'b0;
   logic         rst, start, avg_halt, avg_wr, q_full;
   logic [1:0]   pattern;
   logic [3:0]   intensity, avg_int, q_int;
   logic [W-1:0] avg_sx, avg_sy, avg_ex, avg_ey;
   logic [W-1:0] q_sx, q_sy, q_ex, q_ey;
   logic         q_wr, busy, done;

   line_pattern_writer #(.LINE_W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .intensity(intensity),
      .avg_halt(avg_halt), .avg_wr(avg_wr), .avg_sx(avg_sx), .avg_sy(avg_sy),
      .avg_ex(avg_ex), .avg_ey(avg_ey), .avg_int(avg_int), .q_full(q_full),
      .q_wr(q_wr), .q_sx(q_sx), .q_sy(q_sy), .q_ex(q_ex), .q_ey(q_ey),
      .q_int(q_int), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      int sx, sy, ex, ey, in, c;
   } exp_t;

   exp_t wq[$];
   int   dq[$];
   bit   mon_en = 1'b0;

   function automatic exp_t line_of(input int p, input int i, input int in, input int c);
      exp_t e;
      e.in = in;
      e.c  = c;
      e.sx = 0; e.sy = 0; e.ex = 0; e.ey = 0;
      case (p)
         0: case (i)
               0: begin e.sx = 0;   e.sy = 0;   e.ex = 639; e.ey = 0;   end
               1: begin e.sx = 639; e.sy = 0;   e.ex = 639; e.ey = 479; end
               2: begin e.sx = 639; e.sy = 479; e.ex = 0;   e.ey = 479; end
               default: begin e.sx = 0; e.sy = 479; e.ex = 0; e.ey = 0; end
            endcase
         1: if (i == 0) begin e.sx = 304; e.sy = 240; e.ex = 336; e.ey = 240; end
            else        begin e.sx = 320; e.sy = 224; e.ex = 320; e.ey = 256; end
         default: if (i < 8) begin e.sx = 80 * i; e.sy = 0; e.ex = 80 * i; e.ey = 479; end
                  else begin e.sx = 0; e.sy = 60 * (i - 8); e.ex = 639; e.ey = 60 * (i - 8); end
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      int   d;
      if (mon_en) begin
         if (q_wr) begin
            if (wq.size() == 0) check("wr_unexpected", q_wr, 0);
            else begin
               e = wq.pop_front();
               check("wr_cycle", cyc, e.c);
               check("wr_sx", q_sx, e.sx);
               check("wr_sy", q_sy, e.sy);
               check("wr_ex", q_ex, e.ex);
               check("wr_ey", q_ey, e.ey);
               check("wr_int", q_int, e.in);
            end
         end
         if (done) begin
            if (dq.size() == 0) check("done_unexpected", done, 0);
            else begin
               d = dq.pop_front();
               check("done_cycle", cyc, d);
            end
         end
      end
   end

   int t0 = 0;
   int qf_lo, qf_hi, aw_rel, halt_from, st2_rel, rst_rel;

   task automatic clear_ctrl();
      qf_lo = -10; qf_hi = -11; aw_rel = -10; halt_from = -1000;
      st2_rel = -10; rst_rel = -10;
   endtask

   task automatic drive_ctrl();
      int rel;
      rel      = cyc - t0;
      q_full   = (rel >= qf_lo && rel <= qf_hi);
      avg_wr   = (rel == aw_rel);
      avg_halt = (rel >= halt_from);
      rst      = (rel == rst_rel);
      if (rel == st2_rel) begin
         start   = 1'b1;
         pattern = 2'd1;
      end else begin
         start = 1'b0;
      end
   endtask

   // Cycle 0 carries start; returns at the beginning of cycle 1.
   task automatic go(input int p, input int in);
      t0 = cyc;
      drive_ctrl();
      start     = 1'b1;
      pattern   = 2'(p);
      intensity = 4'(in);
      @(posedge clk); #1;
      pattern   = 2'd0;
      intensity = 4'd0;
      start     = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         drive_ctrl();
         @(posedge clk); #1;
      end
   endtask

   task automatic settle();
      int k;
      k = 0;
      while ((wq.size() != 0 || dq.size() != 0) && k < 200) begin
         drive_ctrl();
         @(posedge clk); #1;
         k++;
      end
      check("pending_writes", wq.size(), 0);
      check("pending_done", dq.size(), 0);
      run(4);
      wq.delete();
      dq.delete();
      clear_ctrl();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_ctrl();
      rst = 1'b1; start = 1'b0; pattern = 2'd0; intensity = 4'd0;
      avg_halt = 1'b1; avg_wr = 1'b1; q_full = 1'b0;
      avg_sx = 13'd1; avg_sy = 13'd2; avg_ex = 13'd3; avg_ey = 13'd4; avg_int = 4'd9;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_qwr_avg", q_wr, 1);
      check("rst_qsx_avg", q_sx, 1);
      check("rst_qint_avg", q_int, 9);
      avg_wr = 1'b0;
      #1;
      check("rst_qwr_idle", q_wr, 0);
      check("rst_qsx_idle", q_sx, 0);
      check("rst_qey_idle", q_ey, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;
      run(2);

      // Border, no stalls, with per-cycle busy window.
      for (int n = 0; n < 4; n++) wq.push_back(line_of(0, n, 5, cyc + 1 + 2 * n));
      dq.push_back(cyc + 9);
      go(0, 5);
      for (int k = 1; k <= 10; k++) begin
         drive_ctrl();
         @(negedge clk);
         check("border_busy", busy, (k <= 9) ? 1 : 0);
         @(posedge clk); #1;
      end
      settle();

      // Grid with queue full in cycles 4..7.
      qf_lo = 4; qf_hi = 7;
      for (int n = 0; n < 16; n++)
         wq.push_back(line_of(2, n, 12, cyc + 1 + 2 * n + ((n >= 2) ? 3 : 0)));
      dq.push_back(cyc + 36);
      go(2, 12);
      settle();

      // Crosshair yielding to an AVG write in cycle 1.
      aw_rel = 1;
      begin
         exp_t a;
         a.sx = 1; a.sy = 2; a.ex = 3; a.ey = 4; a.in = 9; a.c = cyc + 1;
         wq.push_back(a);
      end
      wq.push_back(line_of(1, 0, 3, cyc + 2));
      wq.push_back(line_of(1, 1, 3, cyc + 4));
      dq.push_back(cyc + 6);
      go(1, 3);
      settle();

      // AVG not halted until cycle 10.
      halt_from = 10;
      wq.push_back(line_of(1, 0, 7, cyc + 10));
      wq.push_back(line_of(1, 1, 7, cyc + 12));
      dq.push_back(cyc + 14);
      go(1, 7);
      @(negedge clk);
      check("halt_busy", busy, 1);
      @(posedge clk); #1;
      settle();

      // Pattern 3: done immediately, nothing written.
      dq.push_back(cyc + 1);
      go(3, 1);
      @(negedge clk);
      check("none_busy", busy, 1);
      @(posedge clk); #1;
      settle();

      // Second start while busy is ignored.
      st2_rel = 3;
      for (int n = 0; n < 4; n++) wq.push_back(line_of(0, n, 2, cyc + 1 + 2 * n));
      dq.push_back(cyc + 9);
      go(0, 2);
      settle();

      // Reset in cycle 4 of the grid, then a fresh grid from line 0.
      rst_rel = 4;
      wq.push_back(line_of(2, 0, 6, cyc + 1));
      wq.push_back(line_of(2, 1, 6, cyc + 3));
      go(2, 6);
      run(4);
      @(negedge clk);
      check("rst_mid_busy", busy, 0);
      @(posedge clk); #1;
      run(6);
      settle();
      for (int n = 0; n < 16; n++) wq.push_back(line_of(2, n, 4, cyc + 1 + 2 * n));
      dq.push_back(cyc + 33);
      go(2, 4);
      settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
